timer_counter: RTL

Memory-mapped programmable countdown timer on the CPU data bus, directly upstream of the `mips` core's `interrupt` input. The core writes and reads its three word registers through the same address, byte-enable and write-data signals it drives toward data memory. The timer counts down from a preset value and raises an interrupt request, either once (mode 0) or periodically with auto-reload (mode 1).

---
 rtl/timer_counter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped programmable countdown timer. It sits on the CPU data bus and
// drives the core's interrupt input. The timer has three word registers at
// BASE+0x0 .. BASE+0x8:
//   CTRL   @+0x0  [0] EN, [2:1] MODE, [3] IM (1 = irq allowed); others read 0
//   PRESET @+0x4  reload value, full 32 bits, read/write
//   COUNT  @+0x8  current count, read-only (writes are dropped)
//
// Mode 0 is one-shot: the irq flag stays set until a CTRL write or reset.
// Mode 1 auto-reloads from PRESET and pulses irq for one cycle per period.
// MODE values 2 and 3 behave as mode 0.
//
// Compile-time option:
//   TC_MODE1_EN  defined   -> mode 1 (auto-reload, pulsed irq) is supported.
//                undefined -> CTRL[2:1] is tied to 0 and ignores writes; the
//                             timer always runs as mode 0.
//
// Ports:
//   clk     system clock, all state changes on the rising edge
//   reset   synchronous, active-high reset
//   addr    byte address from the core, bits [1:0] ignored
//   byteen  per-byte write enables; any set bit plus an address hit = write
//   wdata   write data, byte lanes aligned with byteen
//   rdata   combinational read data of the addressed register, 0 on a miss
//   irq     interrupt request = registered irq flag masked by IM
// ---------------------------------------------------------------------------
module timer_counter #(
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // FSM encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  // Word indices of the three registers; decoding ignores addr[1:0].
  localparam logic [29:0] WORD_CTRL   = BASE[31:2];
  localparam logic [29:0] WORD_PRESET = BASE[31:2] + 30'd1;
  localparam logic [29:0] WORD_COUNT  = BASE[31:2] + 30'd2;

  logic [1:0]  state;
  logic [31:0] count;
  logic [31:0] preset;
  logic [31:0] preset_next;
  logic        ctrl_en;
  logic        ctrl_im;
  logic [1:0]  ctrl_mode;
  logic        irq_flag;

  logic        hit_ctrl;
  logic        hit_preset;
  logic        hit_count;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        reload;
  logic        flag_set;
  logic        fsm_clear_en;
  logic        addr_unused;

  // The byte offset inside a word carries no meaning for this block.
  assign addr_unused = ^addr[1:0];

  // Address decode. A write needs an address hit and at least one byte lane.
  assign hit_ctrl   = (addr[31:2] == WORD_CTRL);
  assign hit_preset = (addr[31:2] == WORD_PRESET);
  assign hit_count  = (addr[31:2] == WORD_COUNT);
  assign wr_ctrl    = hit_ctrl   && (byteen != 4'b0000);
  assign wr_preset  = hit_preset && (byteen != 4'b0000);

  // Byte-lane merge for PRESET: unselected lanes keep their current value.
  always_comb begin
    preset_next = preset;
    for (int i = 0; i < 4; i++) begin
      if (byteen[i]) begin
        preset_next[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

`ifdef TC_MODE1_EN
  // MODE lives entirely in byte lane 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_mode <= 2'b00;
    end else if (wr_ctrl && byteen[0]) begin
      ctrl_mode <= wdata[2:1];
    end
  end

  // Only MODE=1 reloads; 2 and 3 fall back to one-shot behaviour.
  assign reload = (ctrl_mode == 2'b01);
`else
  assign ctrl_mode = 2'b00;
  assign reload    = 1'b0;
`endif

  // Expiry is detected while counting with EN still set and COUNT at 0.
  assign flag_set     = (state == S_CNT) && ctrl_en && (count == 32'd0);
  // One-shot expiry disarms the timer on its way back to IDLE.
  assign fsm_clear_en = (state == S_INT) && !reload;

  // CTRL EN/IM and the irq flag. A CPU write to CTRL wins over the FSM
  // clearing EN, and any CTRL write clears the flag even if EN is unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en  <= 1'b0;
      ctrl_im  <= 1'b0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        if (byteen[0]) begin
          ctrl_en <= wdata[0];
          ctrl_im <= wdata[3];
        end
      end else if (fsm_clear_en) begin
        ctrl_en <= 1'b0;
      end

      if (wr_ctrl || ((state == S_INT) && reload)) begin
        irq_flag <= 1'b0;
      end else if (flag_set) begin
        irq_flag <= 1'b1;
      end
    end
  end

  // PRESET register. LOAD samples the value held before this edge, so a
  // PRESET write coinciding with LOAD only affects the following reload.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= 32'd0;
    end else if (wr_preset) begin
      preset <= preset_next;
    end
  end

  // Countdown FSM. The decrement is gated at zero so COUNT never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      count <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl_en) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!ctrl_en) begin
            state <= S_IDLE;
          end else if (count == 32'd0) begin
            state <= S_INT;
          end else begin
            count <= count - 32'd1;
          end
        end
        S_INT: begin
          if (reload) begin
            state <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rdata = 32'd0;
    if (hit_ctrl) begin
      rdata = {28'd0, ctrl_im, ctrl_mode, ctrl_en};
    end else if (hit_preset) begin
      rdata = preset;
    end else if (hit_count) begin
      rdata = count;
    end
  end

  // Only the IM mask sits between the registered flag and the pin.
  assign irq = irq_flag & ctrl_im;

endmodule
